// File: rtl/mc_rv_core.sv
// mc_rv_core: multi-cycle RV32I/RV32E integer core.
// PAUSE -> FETCH -> DECODE -> EXEC -> WB, with an illegal-instruction HALT.
//
// Fetch handshake: imem_req is high exactly while in FETCH, and imem_addr
// (the PC) is held constant for that whole time. A transfer completes on the
// rising edge where imem_req and imem_ack are both 1; imem_rdata is sampled
// only then. imem_ack is ignored in every other state.
module mc_rv_core #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          NUM_REGS = 32
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        run,
   input  logic        step,
   output logic        halted,
   output logic [3:0]  fr,
   output logic [31:0] instret,
   input  logic [2:0]  dbg_sel,
   output logic [31:0] dbg_data,
   output logic [2:0]  dbg_state
);

   localparam int RAW = $clog2(NUM_REGS);

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LUI = 7'b0110111;

   typedef enum logic [2:0] {
      PAUSE  = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, ir_q, a_q, b_q, f_q, instret_q, dbg_q;
   logic [3:0]  fr_q;
   logic [31:0] regs_q [NUM_REGS];

   // Instruction fields, decoded from IR.
   logic [6:0]  opcode, funct7;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic        is_r, is_i, is_lui;
   logic [31:0] imm_i, imm_u;

   assign opcode = ir_q[6:0];
   assign rd     = ir_q[11:7];
   assign funct3 = ir_q[14:12];
   assign rs1    = ir_q[19:15];
   assign rs2    = ir_q[24:20];
   assign funct7 = ir_q[31:25];
   assign is_r   = (opcode == OP_R);
   assign is_i   = (opcode == OP_I);
   assign is_lui = (opcode == OP_LUI);
   assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
   assign imm_u  = {ir_q[31:12], 12'b0};

   // True when a register index exists in this register file (RV32E limit).
   function automatic logic reg_ok(input logic [4:0] idx);
      return ({27'b0, idx} < 32'(NUM_REGS));
   endfunction

   // Legality check: unknown opcodes, bad funct7/shift encodings, RV32E indices.
   logic illegal;
   always_comb begin
      illegal = 1'b0;
      case (opcode)
         OP_R: begin
            if (funct7 != 7'b0000000 &&
                !(funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)))
               illegal = 1'b1;
            if (!reg_ok(rs1) || !reg_ok(rs2) || !reg_ok(rd))
               illegal = 1'b1;
         end
         OP_I: begin
            if (funct3 == 3'b001 && funct7 != 7'b0000000)
               illegal = 1'b1;
            if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000)
               illegal = 1'b1;
            if (!reg_ok(rs1) || !reg_ok(rd))
               illegal = 1'b1;
         end
         OP_LUI: begin
            if (!reg_ok(rd))
               illegal = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
   end

   // Register-file read ports; x0 and non-existent registers read as zero.
   logic [31:0] rs1_val, rs2_val;
   always_comb begin
      rs1_val = 32'b0;
      rs2_val = 32'b0;
      if (rs1 != 5'd0 && reg_ok(rs1))
         rs1_val = regs_q[rs1[RAW-1:0]];
      if (rs2 != 5'd0 && reg_ok(rs2))
         rs2_val = regs_q[rs2[RAW-1:0]];
   end

   // ALU: result and {ZF, CF, OF, SF}; bit 30 selects SUB/SRA/SRAI.
   logic [31:0]        op_b, alu_res, diff;
   logic [32:0]        sum;
   logic signed [31:0] a_s;
   logic [4:0]         shamt;
   logic               cf, of;
   always_comb begin
      op_b    = is_r ? b_q : imm_i;
      shamt   = op_b[4:0];
      sum     = {1'b0, a_q} + {1'b0, op_b};
      diff    = a_q - op_b;
      a_s     = $signed(a_q);
      alu_res = 32'b0;
      cf      = 1'b0;
      of      = 1'b0;
      case (funct3)
         3'b000: begin
            if (is_r && ir_q[30]) begin
               alu_res = diff;
               cf      = (a_q < op_b);
               of      = (a_q[31] ^ op_b[31]) & (diff[31] ^ a_q[31]);
            end else begin
               alu_res = sum[31:0];
               cf      = sum[32];
               of      = ~(a_q[31] ^ op_b[31]) & (sum[31] ^ a_q[31]);
            end
         end
         3'b001: alu_res = a_q << shamt;
         3'b010: alu_res = {31'b0, ($signed(a_q) < $signed(op_b))};
         3'b011: alu_res = {31'b0, (a_q < op_b)};
         3'b100: alu_res = a_q ^ op_b;
         3'b101: alu_res = ir_q[30] ? 32'(a_s >>> shamt) : (a_q >> shamt);
         3'b110: alu_res = a_q | op_b;
         default: alu_res = a_q & op_b;
      endcase
      if (is_lui)
         alu_res = imm_u;
   end

   logic [31:0] wb_data;
   assign wb_data = is_lui ? imm_u : f_q;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= PAUSE;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         PAUSE:  if (run || step) state_d = FETCH;
         FETCH:  if (imem_ack) state_d = DECODE;
         DECODE: state_d = illegal ? HALT : EXEC;
         EXEC:   state_d = WB;
         WB:     state_d = run ? FETCH : PAUSE;
         HALT:   state_d = HALT;
         default: state_d = PAUSE;
      endcase
   end

   // Datapath registers: PC/IR on fetch, operands on decode, result and flags on execute.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q      <= RESET_PC;
         ir_q      <= 32'b0;
         a_q       <= 32'b0;
         b_q       <= 32'b0;
         f_q       <= 32'b0;
         fr_q      <= 4'b0;
         instret_q <= 32'b0;
      end else begin
         case (state_q)
            FETCH: if (imem_ack) begin
               ir_q <= imem_rdata;
               pc_q <= pc_q + 32'd4;
            end
            DECODE: begin
               a_q <= rs1_val;
               b_q <= rs2_val;
            end
            EXEC: begin
               f_q <= alu_res;
               if (!is_lui)
                  fr_q <= {(alu_res == 32'b0), cf, of, alu_res[31]};
            end
            WB: instret_q <= instret_q + 32'd1;
            default: ;
         endcase
      end
   end

   // Register-file write at the edge that ends WB; x0 is never written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs_q[i] <= 32'b0;
      end else if (state_q == WB && rd != 5'd0) begin
         regs_q[rd[RAW-1:0]] <= wb_data;
      end
   end

   // Registered debug read-out for the LED display.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dbg_q <= 32'b0;
      end else begin
         case (dbg_sel)
            3'd0: dbg_q <= pc_q;
            3'd1: dbg_q <= ir_q;
            3'd2: dbg_q <= wb_data;
            3'd3: dbg_q <= a_q;
            3'd4: dbg_q <= b_q;
            3'd5: dbg_q <= f_q;
            3'd6: dbg_q <= {28'b0, fr_q};
            default: dbg_q <= instret_q;
         endcase
      end
   end

   assign imem_req  = (state_q == FETCH);
   assign imem_addr = pc_q;
   assign halted    = (state_q == HALT);
   assign fr        = fr_q;
   assign instret   = instret_q;
   assign dbg_data  = dbg_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_mc_rv_core.sv
// Testbench for mc_rv_core: instruction-memory responder with wait states,
// ISA reference model feeding a writeback scoreboard, directed and random programs.
module tb_mc_rv_core;

   localparam logic [2:0] S_PAUSE  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        imem_req, imem_ack = 1'b0;
   logic [31:0] imem_addr, imem_rdata = 32'b0;
   logic        run = 1'b0, step = 1'b0, halted;
   logic [3:0]  fr;
   logic [31:0] instret, dbg_data;
   logic [2:0]  dbg_sel = 3'd2, dbg_state;

   logic        e_rst = 1'b1;
   logic        e_req, e_ack = 1'b0;
   logic [31:0] e_addr, e_rdata = 32'b0;
   logic        e_run = 1'b0, e_step = 1'b0, e_halted;
   logic [3:0]  e_fr;
   logic [31:0] e_instret, e_dbg_data;
   logic [2:0]  e_dbg_sel = 3'd0, e_dbg_state;

   mc_rv_core #(.RESET_PC(32'h0), .NUM_REGS(32)) dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .run(run), .step(step),
      .halted(halted), .fr(fr), .instret(instret), .dbg_sel(dbg_sel),
      .dbg_data(dbg_data), .dbg_state(dbg_state));

   mc_rv_core #(.RESET_PC(32'h0), .NUM_REGS(16)) dut_e (
      .clk(clk), .rst(e_rst), .imem_req(e_req), .imem_addr(e_addr),
      .imem_ack(e_ack), .imem_rdata(e_rdata), .run(e_run), .step(e_step),
      .halted(e_halted), .fr(e_fr), .instret(e_instret), .dbg_sel(e_dbg_sel),
      .dbg_data(e_dbg_data), .dbg_state(e_dbg_state));

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- encoders ----------------
   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {imm, rs1, f3, rd, 7'b0010011};
   endfunction

   function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
      return {imm, rd, 7'b0110111};
   endfunction

   // ---------------- reference model + scoreboard ----------------
   logic [31:0] mx [32];
   logic [3:0]  mfr;
   logic [31:0] exp_q [$];
   logic [4:0]  exp_rd_q [$];
   logic [3:0]  exp_fr_q [$];

   function automatic void model_exec(input logic [31:0] ins);
      logic [6:0]  op  = ins[6:0];
      logic [4:0]  rd  = ins[11:7];
      logic [2:0]  f3  = ins[14:12];
      logic        alt = ins[30];
      logic [31:0] a   = mx[ins[19:15]];
      logic [31:0] b;
      logic [31:0] r;
      logic [32:0] wide;
      logic        cf = 1'b0, of = 1'b0;
      longint      s;
      if (op == 7'b0110111) begin
         r = {ins[31:12], 12'b0};
      end else begin
         b = (op == 7'b0110011) ? mx[ins[24:20]] : {{20{ins[31]}}, ins[31:20]};
         case (f3)
            3'd0: if (op == 7'b0110011 && alt) begin
               r  = a - b;
               cf = (a < b);
               s  = longint'($signed(a)) - longint'($signed(b));
               of = (s != longint'($signed(r)));
            end else begin
               wide = {1'b0, a} + {1'b0, b};
               r    = wide[31:0];
               cf   = wide[32];
               s    = longint'($signed(a)) + longint'($signed(b));
               of   = (s != longint'($signed(r)));
            end
            3'd1: r = a << b[4:0];
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: r = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'd6: r = a | b;
            default: r = a & b;
         endcase
         mfr = {(r == 32'd0), cf, of, r[31]};
      end
      if (rd != 5'd0) mx[rd] = r;
      exp_q.push_back(r);
      exp_rd_q.push_back(rd);
      exp_fr_q.push_back(mfr);
   endfunction

   function automatic logic [31:0] rand_instr();
      int          k   = $urandom_range(0, 9);
      logic [4:0]  rd  = 5'($urandom_range(0, 7));
      logic [4:0]  rs1 = 5'($urandom_range(0, 7));
      logic [4:0]  rs2 = 5'($urandom_range(0, 7));
      logic [2:0]  f3  = 3'($urandom_range(0, 7));
      logic [6:0]  f7  = 7'b0;
      logic [11:0] imm = 12'($urandom);
      logic [19:0] uimm = 20'($urandom);
      if (k < 4) begin
         if ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) f7 = 7'h20;
         return enc_r(f7, rs2, rs1, f3, rd);
      end else if (k < 8) begin
         if (f3 == 3'd1) imm[11:5] = 7'h00;
         if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
         return enc_i(imm, rs1, f3, rd);
      end
      return enc_u(uimm, rd);
   endfunction

   // Monitor: one cycle after WB the write has landed and dbg_data shows wb data.
   logic wb_seen = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         wb_seen = 1'b0;
      end else begin
         if (wb_seen) begin
            if (exp_q.size() == 0) begin
               check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
               logic [31:0] e;
               logic [4:0]  erd;
               logic [3:0]  efr;
               e   = exp_q.pop_front();
               erd = exp_rd_q.pop_front();
               efr = exp_fr_q.pop_front();
               if (dbg_sel == 3'd2) check("wb_data", dbg_data, e);
               check("flags", {28'b0, fr}, {28'b0, efr});
               if (erd != 5'd0) check("rf_write", dut.regs_q[erd], e);
            end
         end
         wb_seen = (dbg_state == S_WB);
      end
   end

   // ---------------- instruction memory responder ----------------
   logic [31:0] imem [64];
   int          waits = 0;
   bit          rand_waits = 1'b0;
   int          wcnt = 0, cur_wait = 0;
   bit          have_prev = 1'b0;
   logic [31:0] prev_addr = 32'b0;

   always @(negedge clk) begin
      if (rst) begin
         imem_ack  = 1'b0;
         wcnt      = 0;
         have_prev = 1'b0;
         cur_wait  = rand_waits ? $urandom_range(0, 3) : waits;
      end else if (imem_req) begin
         if (have_prev) check("addr_hold", imem_addr, prev_addr);
         if (wcnt >= cur_wait) begin
            imem_ack   = 1'b1;
            imem_rdata = imem[imem_addr[7:2]];
            wcnt       = 0;
            have_prev  = 1'b0;
            cur_wait   = rand_waits ? $urandom_range(0, 3) : waits;
         end else begin
            imem_ack  = 1'b0;
            wcnt++;
            have_prev = 1'b1;
            prev_addr = imem_addr;
         end
      end else begin
         imem_ack  = 1'b0;
         have_prev = 1'b0;
      end
   end

   // RV32E instance memory: a legal addi x5 then addi x20 (illegal with 16 regs).
   always @(negedge clk) begin
      e_ack   = e_req & ~e_rst;
      e_rdata = (e_addr == 32'd0) ? enc_i(12'd3, 5'd0, 3'd0, 5'd5)
                                  : enc_i(12'd1, 5'd0, 3'd0, 5'd20);
   end

   // ---------------- driver tasks ----------------
   logic [31:0] prog [$];

   task automatic start_reset();
      rst  = 1'b1;
      run  = 1'b0;
      step = 1'b0;
      repeat (2) @(negedge clk);
      exp_q.delete();
      exp_rd_q.delete();
      exp_fr_q.delete();
      for (int i = 0; i < 32; i++) mx[i] = 32'b0;
      mfr = 4'b0;
   endtask

   task automatic load_prog(input bit push);
      for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0073;
      for (int i = 0; i < prog.size(); i++) begin
         imem[i] = prog[i];
         if (push) model_exec(prog[i]);
      end
   endtask

   task automatic wait_instret(input logic [31:0] target, input int budget, output int cyc);
      cyc = 0;
      while (instret != target && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      check("instret_reach", instret, target);
   endtask

   task automatic wait_state(input logic [2:0] target, input int budget);
      int cyc = 0;
      while (dbg_state != target && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      check("state_reach", {29'b0, dbg_state}, {29'b0, target});
   endtask

   task automatic read_pc(output logic [31:0] pc);
      dbg_sel = 3'd0;
      @(negedge clk);
      @(negedge clk);
      pc = dbg_data;
      dbg_sel = 3'd2;
   endtask

   task automatic pulse_step();
      @(negedge clk);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int          cyc;
      logic [31:0] pc;

      // Reset state and zero-wait directed program ending in an illegal word at 0x10.
      waits = 0;
      rand_waits = 1'b0;
      start_reset();
      check("rst_req", {31'b0, imem_req}, 32'd0);
      check("rst_halted", {31'b0, halted}, 32'd0);
      check("rst_instret", instret, 32'd0);
      check("rst_fr", {28'b0, fr}, 32'd0);
      check("rst_dbg", dbg_data, 32'd0);
      check("rst_state", {29'b0, dbg_state}, {29'b0, S_PAUSE});
      prog = '{enc_i(12'd5, 5'd0, 3'd0, 5'd1),
               enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2),
               enc_u(20'h80000, 5'd3),
               enc_r(7'h20, 5'd3, 5'd0, 3'd0, 5'd4)};
      load_prog(1'b1);
      run = 1'b1;
      rst = 1'b0;
      @(negedge clk);
      check("first_req", {31'b0, imem_req}, 32'd1);
      check("first_addr", imem_addr, 32'd0);
      wait_instret(32'd2, 40, cyc);
      check("lat_2instr", cyc, 32'd8);
      check("x2_ten", dut.regs_q[2], 32'd10);
      wait_state(S_HALT, 40);
      read_pc(pc);
      check("halt_pc", pc, 32'h14);
      check("halt_instret", instret, 32'd4);
      check("x4_val", dut.regs_q[4], 32'h8000_0000);
      check("sub_flags", {28'b0, fr}, 32'b0111);
      check("sb_drained", 32'(exp_q.size()), 32'd0);
      // Halt is sticky against run/step activity.
      pulse_step();
      run = 1'b0;
      pulse_step();
      run = 1'b1;
      repeat (10) @(negedge clk);
      check("halt_sticky", {31'b0, halted}, 32'd1);
      check("halt_noreq", {31'b0, imem_req}, 32'd0);
      check("halt_noret", instret, 32'd4);
      read_pc(pc);
      check("halt_pc_hold", pc, 32'h14);

      // Three wait states per fetch: 7 cycles per instruction, same results.
      waits = 3;
      start_reset();
      load_prog(1'b1);
      run = 1'b1;
      rst = 1'b0;
      wait_instret(32'd1, 40, cyc);
      wait_instret(32'd2, 40, cyc);
      check("lat_wait3", cyc, 32'd7);
      wait_state(S_HALT, 80);
      read_pc(pc);
      check("w3_halt_pc", pc, 32'h14);
      check("w3_x2", dut.regs_q[2], 32'd10);

      // Single-step: one instruction per step pulse, PAUSE in between.
      waits = 0;
      start_reset();
      prog = '{enc_i(12'd7, 5'd0, 3'd0, 5'd5),
               enc_i(12'hfff, 5'd5, 3'd4, 5'd6),
               enc_i(12'd0, 5'd6, 3'd2, 5'd7),
               enc_i(12'd1, 5'd5, 3'd3, 5'd8)};
      load_prog(1'b1);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("paused_idle", instret, 32'd0);
      check("paused_noreq", {31'b0, imem_req}, 32'd0);
      pulse_step();
      wait_instret(32'd1, 20, cyc);
      repeat (10) @(negedge clk);
      check("step1_hold", instret, 32'd1);
      check("step1_state", {29'b0, dbg_state}, {29'b0, S_PAUSE});
      pulse_step();
      wait_instret(32'd2, 20, cyc);
      repeat (10) @(negedge clk);
      check("step2_hold", instret, 32'd2);
      // run dropped mid-instruction: it completes, then the core pauses.
      run = 1'b1;
      wait_state(S_DECODE, 20);
      run = 1'b0;
      wait_instret(32'd3, 20, cyc);
      check("runfall_state", {29'b0, dbg_state}, {29'b0, S_PAUSE});
      repeat (5) @(negedge clk);
      check("runfall_hold", instret, 32'd3);
      check("runfall_left", 32'(exp_q.size()), 32'd1);

      // Random ALU program with random wait states.
      rand_waits = 1'b1;
      start_reset();
      prog.delete();
      for (int i = 0; i < 24; i++) prog.push_back(rand_instr());
      load_prog(1'b1);
      run = 1'b1;
      rst = 1'b0;
      wait_state(S_HALT, 600);
      check("rand_instret", instret, 32'd24);
      read_pc(pc);
      check("rand_pc", pc, 32'd100);
      check("rand_drained", 32'(exp_q.size()), 32'd0);
      for (int i = 1; i < 8; i++) check("rand_regs", dut.regs_q[i], mx[i]);

      // Reset mid-fetch with ack pending: request drops at once, nothing retires.
      rand_waits = 1'b0;
      waits = 6;
      start_reset();
      prog = '{enc_i(12'd9, 5'd0, 3'd0, 5'd1)};
      load_prog(1'b0);
      run = 1'b1;
      rst = 1'b0;
      @(negedge clk);
      check("mid_req_up", {31'b0, imem_req}, 32'd1);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("mid_req_drop", {31'b0, imem_req}, 32'd0);
      check("mid_state", {29'b0, dbg_state}, {29'b0, S_PAUSE});
      check("mid_instret", instret, 32'd0);
      waits = 0;
      start_reset();
      check("mid_nowrite", dut.regs_q[1], 32'd0);
      load_prog(1'b1);
      run = 1'b1;
      rst = 1'b0;
      wait_instret(32'd1, 20, cyc);
      check("mid_recover", dut.regs_q[1], 32'd9);

      // RV32E instance: addi x5 retires, addi x20 halts.
      @(negedge clk);
      e_run = 1'b1;
      e_rst = 1'b0;
      cyc = 0;
      while (!e_halted && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("e_halted", {31'b0, e_halted}, 32'd1);
      check("e_instret", e_instret, 32'd1);
      check("e_x5", dut_e.regs_q[5], 32'd3);
      @(negedge clk);
      check("e_pc", e_dbg_data, 32'd8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mc_rv_core.md
# mc_rv_core

Parametrised multi-cycle RV32I integer core: the successor to the current single-issue CPU top. It sequences fetch, decode, execute and writeback through an explicit state machine, and fetches from an external instruction memory over a req/ack handshake that tolerates wait states. New over the previous generation: RV32E register-count option, illegal-instruction halt, single-step mode, a retired-instruction counter, and a registered debug read-out mux for the LED display block.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NUM_REGS`, default 32: register-file depth. Legal values are 32 (RV32I) and 16 (RV32E).
- `clk` in, 1: single clock; all state updates on the rising edge.
- `rst` in, 1: reset, asynchronous and active-high.
- `imem_req` out, 1: fetch request.
- `imem_addr` out, 32: fetch address, equal to PC.
- `imem_ack` in, 1: fetch data valid this cycle.
- `imem_rdata` in, 32: instruction word, sampled when `imem_ack` is 1.
- `run` in, 1: 1 = free-running; 0 = single-step.
- `step` in, 1: one-cycle pulse that releases one instruction while paused.
- `halted` out, 1: core stopped on an illegal instruction.
- `fr` out, 4: flags {ZF, CF, OF, SF}.
- `instret` out, 32: count of retired instructions.
- `dbg_sel` in, 3: debug source select.
- `dbg_data` out, 32: selected debug value, registered.

## Operation
- States: PAUSE, FETCH, DECODE, EXEC, WB, HALT. `rst` forces PAUSE.
- PAUSE:
  - `run` = 1 or `step` = 1 → FETCH; otherwise stay.
- FETCH:
  - `imem_req` = 1, `imem_addr` = PC, both held stable until ack.
  - On `imem_ack`: IR ← `imem_rdata`, PC ← PC+4 (mod 2^32), → DECODE.
- DECODE:
  - A ← x[rs1], B ← x[rs2]; immediate is formed.
  - Illegal instruction → HALT. Otherwise → EXEC.
- EXEC:
  - F ← ALU(A, B or imm).
  - `fr` is updated for every ALU op. LUI leaves `fr` unchanged.
  - → WB.
- WB:
  - x[rd] ← F, or imm for LUI. No write when rd = 0.
  - `instret` += 1, wrapping mod 2^32.
  - → FETCH if `run` = 1, else → PAUSE.
- HALT:
  - Terminal; only `rst` exits.
  - `halted` = 1; PC holds faulting address + 4.
- Supported instructions:
  - R-type: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND.
  - I-type: ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI.
  - LUI.
- Illegal (→ HALT), any of:
  - any other opcode;
  - R-type funct7 not 0000000, or not 0100000 for SUB/SRA;
  - shift-immediate imm[11:5] not 0000000, or not 0100000 for SRAI;
  - with NUM_REGS = 16: rs1, rs2 or rd ≥ 16.
- Flags:
  - ZF = (result == 0); SF = result[31].
  - ADD/ADDI: CF = carry-out of bit 31; OF = signed overflow.
  - SUB: CF = borrow (A <u B); OF = signed overflow.
  - All other ops: CF = OF = 0.
- Shifts use operand[4:0]. SLT/SLTU results are 0 or 1, zero-extended.
- Register file: x0 reads 0. Writes land at the clock edge ending WB, so a following instruction's DECODE sees the new value; no forwarding is needed.
- `dbg_sel` mapping: 0 PC, 1 IR, 2 writeback data, 3 A, 4 B, 5 F, 6 {28'b0, fr}, 7 `instret`.

## Timing
- Reset values:
  - PC = RESET_PC; IR, A, B, F = 0; all registers 0.
  - `fr` = 0, `instret` = 0, `halted` = 0, `dbg_data` = 0.
  - `imem_req` = 0 (it is decoded from state, so it drops asynchronously with `rst`).
- Latency:
  - Minimum 4 cycles per instruction: ack in the first FETCH cycle, then DECODE, EXEC, WB.
  - Each wait-state cycle adds 1.
  - First `imem_req` asserts 1 cycle after reset release when `run` = 1.
- Handshake:
  - `imem_addr` must not change while `imem_req` = 1 and `imem_ack` = 0.
  - `imem_ack` is ignored outside FETCH.
- `dbg_data` lags its source by 1 cycle.
- Simultaneous events:
  - `step` in any state other than PAUSE is ignored.
  - `run` falling mid-instruction lets that instruction complete, then the core enters PAUSE.
- Reset mid-operation, including mid-fetch with ack pending: state returns to PAUSE immediately; any partial instruction is discarded, with no register write and no `instret` increment.

## Test plan
- Zero-wait fetch of `addi x1,x0,5` then `add x2,x1,x1` with `run` = 1 → x2 = 10, `instret` = 2 after 8 cycles, PC = 8.
- Ack delayed 3 cycles on each fetch → `imem_addr` stable throughout, 7 cycles per instruction, same results.
- `lui x3,0x80000` then `sub x4,x0,x3` → x4 = 0x8000_0000 and `fr` = {0,1,1,1}.
- `run` = 0: two `step` pulses 10 cycles apart → exactly one instruction retired per pulse; the core sits in PAUSE between pulses.
- Word 0x0000_0073 at PC 0x10 → `halted` = 1, PC = 0x14, no register written; later `step`/`run` activity has no effect until `rst`.
- NUM_REGS = 16: `addi x20,x0,1` → HALT. Separately, assert `rst` mid-FETCH → `imem_req` low within the same cycle and `instret` unchanged.
